// File: rtl/color_sequence_player.sv
// Plays queued 2-bit color codes on four LEDs: ON_CYCLES lit, then GAP_CYCLES dark per color.
// Latency: push into idle/empty lights the LED after the following edge; back-to-back colors have no idle bubble.
// Backpressure: o_color_ready = !full; valid while not ready is dropped, not held. i_abort flushes everything.
//
// Ports: i_clk, i_rst (sync, active-high), i_color_in/i_color_valid/o_color_ready (push side),
//        i_abort, o_led_green/red/blue/yellow (codes 00/01/10/11), o_busy, o_done (1-cycle), o_tone_out.
// Optional feature macro: COLOR_TONE_EN builds a per-color square-wave tone on o_tone_out during ON;
//        without it o_tone_out is tied low and no divider exists.
module color_sequence_player #(
  parameter int DEPTH      = 4,
  parameter int ON_CYCLES  = 25000000,
  parameter int GAP_CYCLES = 12500000,
  parameter int TONE_HALF  = 25000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_color_in,
  input  logic       i_color_valid,
  output logic       o_color_ready,
  input  logic       i_abort,
  output logic       o_led_green,
  output logic       o_led_red,
  output logic       o_led_blue,
  output logic       o_led_yellow,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tone_out
);

  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  // Counters hold "cycles remaining minus one" so a phase ends when they reach zero.
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [1:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_push, w_pop;
  logic [1:0]    w_head;

  // FSM
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_led, w_led_nxt;
  logic          r_done, w_done_nxt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = i_color_valid && !w_full && !i_abort;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_led_nxt   = r_led;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_led_nxt = 4'b0000;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = ON_LOAD;
          w_led_nxt   = 4'b0001 << w_head;
          w_state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = GAP_LOAD;
          w_led_nxt   = 4'b0000;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (!w_empty) begin
            // Chain straight into the next color without passing through IDLE.
            w_pop       = 1'b1;
            w_cnt_nxt   = ON_LOAD;
            w_led_nxt   = 4'b0001 << w_head;
            w_state_nxt = S_ON;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_led_nxt   = 4'b0000;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_led_nxt   = 4'b0000;
      w_done_nxt  = 1'b0;
      w_pop       = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_led    <= 4'b0000;
      r_done   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_led   <= w_led_nxt;
      r_done  <= w_done_nxt;
      if (i_abort) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_color_in;
  end

  assign o_color_ready = !w_full;
  assign o_led_green   = r_led[0];
  assign o_led_red     = r_led[1];
  assign o_led_blue    = r_led[2];
  assign o_led_yellow  = r_led[3];
  assign o_done        = r_done;
  assign o_busy        = (r_state != S_IDLE) || !w_empty;

`ifdef COLOR_TONE_EN
  localparam int TW = $clog2(4 * TONE_HALF + 1);
  logic [1:0]    r_code;
  logic [1:0]    w_tcode;
  logic [TW-1:0] r_tcnt, w_tload;
  logic          r_tone;

  // Half-period reload for the color being started (on pop) or currently playing.
  assign w_tcode = w_pop ? w_head : r_code;
  always_comb begin
    w_tload = '0;
    case (w_tcode)
      2'd0:    w_tload = TW'(TONE_HALF - 1);
      2'd1:    w_tload = TW'(2 * TONE_HALF - 1);
      2'd2:    w_tload = TW'(3 * TONE_HALF - 1);
      default: w_tload = TW'(4 * TONE_HALF - 1);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code <= 2'b00;
      r_tcnt <= '0;
      r_tone <= 1'b0;
    end else if (w_state_nxt != S_ON) begin
      // Leaving ON (incl. abort) silences the tone.
      r_tcnt <= '0;
      r_tone <= 1'b0;
    end else if (w_pop) begin
      r_code <= w_head;
      r_tcnt <= w_tload;
      r_tone <= 1'b0;
    end else if (r_tcnt == '0) begin
      r_tcnt <= w_tload;
      r_tone <= ~r_tone;
    end else begin
      r_tcnt <= r_tcnt - TW'(1);
    end
  end

  assign o_tone_out = r_tone;
`else
  assign o_tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_color_sequence_player.sv
// Directed bench for color_sequence_player with DEPTH=4, ON_CYCLES=3, GAP_CYCLES=2, TONE_HALF=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_color_sequence_player;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] color_in;
  logic       color_valid;
  logic       color_ready;
  logic       abort;
  logic       led_green, led_red, led_blue, led_yellow;
  logic       busy, done, tone_out;

  int errors = 0;
  int checks = 0;

  color_sequence_player #(
    .DEPTH(4), .ON_CYCLES(3), .GAP_CYCLES(2), .TONE_HALF(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_color_in(color_in), .i_color_valid(color_valid),
    .o_color_ready(color_ready), .i_abort(abort),
    .o_led_green(led_green), .o_led_red(led_red), .o_led_blue(led_blue), .o_led_yellow(led_yellow),
    .o_busy(busy), .o_done(done), .o_tone_out(tone_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] leds();
    return {led_yellow, led_blue, led_red, led_green};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; color_valid = 1'b0; color_in = 2'b00; abort = 1'b0;
    tick();
    tick();
    checks++; if (leds() !== 4'b0000) begin errors++; $display("FAIL reset_leds got %b want 0000", leds()); end
    checks++; if (color_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", color_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL reset_tone got %b want 0", tone_out); end
    rst = 1'b0;
  endtask

  // Single blue: pushed at edge 0, lit after edges 1..3, dark after 4..5, done after 6.
  task automatic test_single();
    logic [3:0] exp_led [8] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       exp_dn  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_bsy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      color_valid = (k == 0);
      color_in    = 2'b10;
      tick();
      color_valid = 1'b0;
      checks++; if (leds() !== exp_led[k]) begin errors++; $display("FAIL single_led k=%0d got %b want %b", k, leds(), exp_led[k]); end
      checks++; if (done !== exp_dn[k]) begin errors++; $display("FAIL single_done k=%0d got %b want %b", k, done, exp_dn[k]); end
      checks++; if (busy !== exp_bsy[k]) begin errors++; $display("FAIL single_busy k=%0d got %b want %b", k, busy, exp_bsy[k]); end
`ifndef COLOR_TONE_EN
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL single_tone k=%0d got %b want 0", k, tone_out); end
`endif
    end
  endtask

  // G,R,B,Y pushed on edges 0..3. Edge 1 already pops G, so the queue peaks at 3 and ready stays 1.
  // Color i is lit for c = 5i..5i+2 (c = edge-1), dark for 5i+3..5i+4, done at c=20.
  task automatic test_back_to_back();
    int c;
    logic [3:0] exp_led;
    for (int k = 0; k <= 22; k++) begin
      color_valid = (k < 4);
      color_in    = k[1:0];
      tick();
      color_valid = 1'b0;
      c = k - 1;
      exp_led = 4'b0000;
      if (c >= 0 && c < 20 && (c % 5) < 3) exp_led = 4'b0001 << (c / 5);
      checks++; if (leds() !== exp_led) begin errors++; $display("FAIL b2b_led k=%0d got %b want %b", k, leds(), exp_led); end
      checks++; if (done !== (c == 20)) begin errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, (c == 20)); end
      checks++; if (busy !== (c < 20)) begin errors++; $display("FAIL b2b_busy k=%0d got %b want %b", k, busy, (c < 20)); end
      checks++; if (color_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got %b want 1", k, color_ready); end
    end
  endtask

  // Y then G,R,B,Y on edges 0..4 fills the queue (4 waiting behind the playing Y).
  // Edge 5 offers red for one cycle while full: it must be dropped, so exactly 5 colors play.
  task automatic test_full_drop();
    logic [1:0] fseq [5] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    int c;
    logic [3:0] exp_led;
    for (int k = 0; k <= 27; k++) begin
      color_valid = (k <= 5);
      color_in    = (k < 5) ? fseq[k] : 2'b01;
      tick();
      color_valid = 1'b0;
      c = k - 1;
      exp_led = 4'b0000;
      if (c >= 0 && c < 25 && (c % 5) < 3) exp_led = 4'b0001 << fseq[c / 5];
      checks++; if (leds() !== exp_led) begin errors++; $display("FAIL full_led k=%0d got %b want %b", k, leds(), exp_led); end
      checks++; if (done !== (c == 25)) begin errors++; $display("FAIL full_done k=%0d got %b want %b", k, done, (c == 25)); end
      checks++; if (color_ready !== !(k == 4 || k == 5)) begin
        errors++; $display("FAIL full_ready k=%0d got %b want %b", k, color_ready, !(k == 4 || k == 5));
      end
`ifndef COLOR_TONE_EN
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL full_tone k=%0d got %b want 0", k, tone_out); end
`endif
    end
  endtask

  // Yellow lit after edges 1,2; abort (with a simultaneous push) during the 2nd lit cycle acts at edge 3.
  task automatic test_abort();
    for (int k = 0; k < 3; k++) begin
      color_valid = (k == 0);
      color_in    = 2'b11;
      tick();
      color_valid = 1'b0;
    end
    checks++; if (leds() !== 4'b1000) begin errors++; $display("FAIL abort_pre_led got %b want 1000", leds()); end
    abort = 1'b1; color_valid = 1'b1; color_in = 2'b00;
    tick();
    abort = 1'b0; color_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (leds() !== 4'b0000) begin errors++; $display("FAIL abort_led k=%0d got %b want 0000", k, leds()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy k=%0d got %b want 0", k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done k=%0d got %b want 0", k, done); end
      checks++; if (color_ready !== 1'b1) begin errors++; $display("FAIL abort_ready k=%0d got %b want 1", k, color_ready); end
      tick();
    end
  endtask

  // Red: tone half-period would be 4 clocks, longer than the 3-cycle ON phase, so tone_out stays 0
  // with or without the tone feature built.
  task automatic test_tone();
    for (int k = 0; k < 8; k++) begin
      color_valid = (k == 0);
      color_in    = 2'b01;
      tick();
      color_valid = 1'b0;
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL tone k=%0d got %b want 0", k, tone_out); end
      checks++; if (led_red !== (k >= 1 && k <= 3)) begin
        errors++; $display("FAIL tone_led k=%0d got %b want %b", k, led_red, (k >= 1 && k <= 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_drop();
    test_abort();
    test_tone();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
